simmem_rsp_release_bank: RTL and testbench
==========================================

Name: simmem_rsp_release_bank

Overview:
- Response-side counterpart of the delay bank in the simulated memory controller.
- Stores incoming write responses in slots and hands the allocated slot identifier to the delay bank.
- Consumes the delay bank's multihot release enables and emits released responses through a valid/ready output register.
- Reports each drained slot back to the delay bank as a one-hot "address released" pulse.

Parameters:
- Capa, simmem_pkg::WRspBankCapa (8): number of response slots; also the width of the one-hot vectors.
- DataW, simmem_pkg::WRspW (32): width of the stored response payload.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_data_i  in  DataW  response payload from the upstream slave
- in_valid_i  in  1  input valid
- in_ready_o  out  1  high when at least one slot is free
- alloc_onehot_o  out  Capa  one-hot slot chosen for the current input; zero when no slot is free; feeds the delay bank local identifier
- release_en_i  in  Capa  multihot: slots whose delay has elapsed
- address_released_onehot_o  out  Capa  one-hot pulse: slot drained this cycle
- out_data_o  out  DataW  released response
- out_valid_o  out  1  output valid
- out_ready_i  in  1  output ready

Behaviour:
- Reset: all slots free, out_valid_o=0, out_data_o=0, round-robin pointer=0. With every slot free, in_ready_o=1 and alloc_onehot_o=1 (slot 0). address_released_onehot_o=0.
- Reset mid-operation discards all stored and pending responses. No released pulse is emitted for discarded slots.
- Allocation:
  - Lowest-index free slot, computed from the registered occupancy vector only.
  - A slot freed in cycle t becomes allocatable in t+1.
  - in_ready_o = |free_q.
  - On in_valid_i && in_ready_o: payload is written to the slot and occupied is set at the edge.
- Candidate set: release_en_i & occupied_q.
  - release_en_i bits on unoccupied slots are ignored; a simulation assertion flags them.
- Output register load condition: load = (|candidates) && (!out_valid_o || out_ready_i).
- On load:
  - Round-robin grant starting at pointer rr_q, searching upward with wrap Capa-1 -> 0.
  - Combinationally in the same cycle: address_released_onehot_o = grant.
  - At the edge: out_data_o <= slot data; out_valid_o <= 1; slot freed; rr_q <= (grant_idx+1) mod Capa.
  - The delay bank clears its enable at the same edge, so the slot is never regranted.
- No load and out_ready_i high: out_valid_o <= 0 at the edge.
- Output hold: out_data_o and out_valid_o stay stable while out_valid_o && !out_ready_i.
- Throughput: one response per cycle when out_ready_i is held high.
- Minimum latency: input accepted at cycle t, delay bank releases at t+1, out_valid_o asserted at t+2.
- Simultaneous allocate and grant: must target different slots. Guaranteed because a granted slot is occupied_q and allocation uses free_q.
- Full (all slots occupied): in_ready_o=0, alloc_onehot_o=0.
- Empty with no candidates: out_valid_o falls after the last handshake.
- address_released_onehot_o has at most one bit set and is high for exactly one cycle per released response.

Decomposition:
- simmem_pkg holds WRspBankCapa, WRspW, and a typedef slot_onehot_t = logic [Capa-1:0].
- One sub-module, simmem_rr_arbiter:
  - Inputs: Capa request vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
- Lowest-free-slot finder is a local function.

Test Plan:
- Reset, then one input 0xA5 with delay-bank stub asserting release_en_i[0] the next cycle, out_ready_i=1 -> alloc_onehot_o=0x01; address_released_onehot_o=0x01 at t+1; out_valid_o=1 with out_data_o=0xA5 at t+2.
- Fill all 8 slots with 0x10..0x17 -> in_ready_o=0 and alloc_onehot_o=0 after the 8th acceptance. Release slot 3 -> in_ready_o=1 the following cycle and alloc_onehot_o=0x08.
- Release enables 0x0F asserted together, out_ready_i=1 -> grants 0x01, 0x02, 0x04, 0x08 on consecutive cycles; out_data_o 0x10..0x13 back-to-back.
- Backpressure: out_ready_i=0 for 5 cycles while release_en_i=0x06 -> out_data_o stays at the first granted value; address_released_onehot_o=0 during the stall; second grant follows on the cycle out_ready_i rises.
- Round-robin fairness: rr pointer at 2, release_en_i=0x81 -> slot 7 granted first, then slot 0.
- Assert rst_i while 4 slots are occupied and out_valid_o=1 -> the next cycle shows out_valid_o=0, in_ready_o=1, alloc_onehot_o=0x01, and no released pulse.

Source files
------------

// File: rtl/simmem_pkg.sv
// Shared sizing for the simulated memory controller's write-response path.
package simmem_pkg;

  localparam int unsigned WRspBankCapa = 32'd8;
  localparam int unsigned WRspW        = 32'd32;

  typedef logic [WRspBankCapa-1:0] slot_onehot_t;

endpackage

// File: rtl/simmem_rsp_release_bank_if.sv
// Handshake bundle between upstream slave, delay bank and the response release bank.
interface simmem_rsp_release_bank_if
  import simmem_pkg::*;
#(
  parameter int unsigned Capa  = WRspBankCapa,
  parameter int unsigned DataW = WRspW
);

  logic [DataW-1:0] in_data_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [Capa-1:0]  alloc_onehot_o;
  logic [Capa-1:0]  release_en_i;
  logic [Capa-1:0]  address_released_onehot_o;
  logic [DataW-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;

  modport slave (
    input  in_data_i, in_valid_i, release_en_i, out_ready_i,
    output in_ready_o, alloc_onehot_o, address_released_onehot_o, out_data_o, out_valid_o
  );

  modport master (
    output in_data_i, in_valid_i, release_en_i, out_ready_i,
    input  in_ready_o, alloc_onehot_o, address_released_onehot_o, out_data_o, out_valid_o
  );

endinterface

// File: rtl/simmem_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or above ptr_i, wrapping at Capa-1.
module simmem_rr_arbiter #(
  parameter int unsigned Capa = 32'd8,
  parameter int unsigned IdxW = 32'd3
) (
  input  logic [Capa-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  input  logic            en_i,
  output logic [Capa-1:0] gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  function automatic logic [IdxW-1:0] pos_of(input logic [IdxW-1:0] ptr, input int unsigned off);
    int unsigned sum;
    sum = 32'(ptr) + off;
    return IdxW'(sum % Capa);
  endfunction

  logic            found_s;
  logic            hit_s;
  logic [IdxW-1:0] pos_s;
  logic [IdxW-1:0] idx_s;

  // Walk the rotated request vector and latch the first hit.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    pos_s   = '0;
    idx_s   = '0;
    for (int unsigned i = 0; i < Capa; i++) begin
      pos_s   = pos_of(ptr_i, i);
      hit_s   = en_i && !found_s && req_i[pos_s];
      idx_s   = hit_s ? pos_s : idx_s;
      found_s = found_s | hit_s;
    end
  end

  assign gnt_idx_o = idx_s;
  assign gnt_o     = found_s ? ({{(Capa-1){1'b0}}, 1'b1} << idx_s) : '0;

endmodule

// File: rtl/simmem_rsp_release_bank_chk.sv
// Simulation-only protocol checks for the response release bank.
module simmem_rsp_release_bank_chk #(
  parameter int unsigned Capa = 32'd8
) (
  input logic            clk_i,
  input logic            rst_i,
  input logic [Capa-1:0] release_en,
  input logic [Capa-1:0] occupied,
  input logic [Capa-1:0] address_released
);

  release_on_free_slot: assert property (@(posedge clk_i) disable iff (rst_i)
    (release_en & ~occupied) == '0)
    else $error("release enable seen on an unoccupied slot");

  single_release_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(address_released))
    else $error("more than one slot released in a cycle");

endmodule

// File: rtl/simmem_rsp_release_bank.sv
// Write-response slot bank: stores responses, releases them on delay-bank enables via a valid/ready register.
module simmem_rsp_release_bank
  import simmem_pkg::*;
#(
  parameter int unsigned Capa  = WRspBankCapa,
  parameter int unsigned DataW = WRspW
) (
  input logic clk_i,
  input logic rst_i,
  simmem_rsp_release_bank_if.slave bank
);

  localparam int unsigned IdxW = (Capa > 32'd1) ? $clog2(Capa) : 32'd1;

  function automatic logic [Capa-1:0] lowest_onehot(input logic [Capa-1:0] vec);
    logic [Capa-1:0] res;
    logic            found;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < Capa; i++) begin
      res[i] = vec[i] && !found;
      found  = found | vec[i];
    end
    return res;
  endfunction

  logic [Capa-1:0]  occupied_r;
  logic [DataW-1:0] data_r [Capa];
  logic [IdxW-1:0]  rr_r;
  logic [DataW-1:0] out_data_r;
  logic             out_valid_r;

  logic [Capa-1:0]  free_s;
  logic [Capa-1:0]  alloc_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [Capa-1:0]  candidates_s;
  logic             load_s;
  logic [Capa-1:0]  grant_s;
  logic [IdxW-1:0]  grant_idx_s;

  // Allocation looks only at registered occupancy, so a slot freed this cycle is reusable next cycle.
  assign free_s       = ~occupied_r;
  assign alloc_s      = lowest_onehot(free_s);
  assign in_ready_s   = |free_s;
  assign accept_s     = bank.in_valid_i && in_ready_s;
  assign candidates_s = bank.release_en_i & occupied_r;
  assign load_s       = (|candidates_s) && (!out_valid_r || bank.out_ready_i);

  simmem_rr_arbiter #(
    .Capa (Capa),
    .IdxW (IdxW)
  ) u_arb (
    .req_i     (candidates_s),
    .ptr_i     (rr_r),
    .en_i      (load_s),
    .gnt_o     (grant_s),
    .gnt_idx_o (grant_idx_s)
  );

  // Occupancy, round-robin pointer and output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occupied_r  <= '0;
      rr_r        <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      occupied_r <= (occupied_r | (accept_s ? alloc_s : '0)) & ~grant_s;
      if (load_s) begin
        out_data_r  <= data_r[grant_idx_s];
        out_valid_r <= 1'b1;
        rr_r        <= (grant_idx_s == IdxW'(Capa - 32'd1)) ? '0 : grant_idx_s + IdxW'(1);
      end else if (bank.out_ready_i) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  // Payload storage; contents of free slots are don't-care, so no reset is needed.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < Capa; i++) begin
      if (accept_s && alloc_s[i]) begin
        data_r[i] <= bank.in_data_i;
      end
    end
  end

  assign bank.in_ready_o                = in_ready_s;
  assign bank.alloc_onehot_o            = alloc_s;
  assign bank.address_released_onehot_o = grant_s;
  assign bank.out_data_o                = out_data_r;
  assign bank.out_valid_o               = out_valid_r;

  simmem_rsp_release_bank_chk #(
    .Capa (Capa)
  ) u_chk (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .release_en       (bank.release_en_i),
    .occupied         (occupied_r),
    .address_released (grant_s)
  );

endmodule

// File: tb/tb_simmem_rsp_release_bank.sv
// Self-checking bench: directed scenarios plus randomized traffic against a slot-level reference model.
module tb_simmem_rsp_release_bank;
  import simmem_pkg::*;

  logic clk_i;
  logic rst_i;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  simmem_rsp_release_bank_if #(.Capa(8), .DataW(32)) bus ();

  simmem_rsp_release_bank #(.Capa(8), .DataW(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bank  (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: slot contents, occupancy, pointer, output register, stub release times.
  bit          m_occ [8];
  logic [31:0] m_data [8];
  int          m_rt [8];
  int          m_rr;
  bit          m_ov;
  logic [31:0] m_od;

  function automatic int m_alloc();
    for (int k = 0; k < 8; k++) if (!m_occ[k]) return k;
    return -1;
  endfunction

  function automatic int m_grant(input logic [7:0] rel, input logic ordy);
    if (m_ov && !ordy) return -1;
    for (int k = 0; k < 8; k++) begin
      int p;
      p = (m_rr + k) % 8;
      if (m_occ[p] && rel[p]) return p;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 8; k++) begin
      m_occ[k] = 1'b0;
      m_rt[k]  = 0;
    end
    m_rr = 0;
    m_ov = 1'b0;
    m_od = 32'h0;
  endtask

  task automatic m_clock();
    int          g;
    int          a;
    logic [31:0] gd;
    g  = m_grant(bus.release_en_i, bus.out_ready_i);
    a  = m_alloc();
    gd = (g >= 0) ? m_data[g] : 32'h0;
    if (bus.in_valid_i && a >= 0) begin
      m_occ[a]  = 1'b1;
      m_data[a] = bus.in_data_i;
      m_rt[a]   = cyc + int'($urandom_range(1, 6));
    end
    if (g >= 0) begin
      m_occ[g] = 1'b0;
      m_od     = gd;
      m_ov     = 1'b1;
      m_rr     = (g + 1) % 8;
    end else if (bus.out_ready_i) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    if (rst_i) m_reset();
    else m_clock();
    cyc++;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] rel, input logic rdy);
    bus.in_valid_i   = v;
    bus.in_data_i    = d;
    bus.release_en_i = rel;
    bus.out_ready_i  = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    adv();
    adv();
    rst_i = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o); end
    n_cmp++; if (bus.out_data_o !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", bus.out_data_o); end
    n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready_o); end
    n_cmp++; if (bus.alloc_onehot_o !== 8'h01) begin n_err++; $display("FAIL reset_alloc got %h want 01", bus.alloc_onehot_o); end
    n_cmp++; if (bus.address_released_onehot_o !== 8'h00) begin n_err++; $display("FAIL reset_released got %h want 00", bus.address_released_onehot_o); end
  endtask

  task automatic test_min_latency();
    drive(1'b1, 32'hA5, 8'h00, 1'b1);
    n_cmp++; if (bus.alloc_onehot_o !== 8'h01) begin n_err++; $display("FAIL lat_alloc got %h want 01", bus.alloc_onehot_o); end
    adv();
    drive(1'b0, 32'h0, 8'h01, 1'b1);
    n_cmp++; if (bus.address_released_onehot_o !== 8'h01) begin n_err++; $display("FAIL lat_released got %h want 01", bus.address_released_onehot_o); end
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL lat_early_valid got %b want 0", bus.out_valid_o); end
    adv();
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'hA5) begin n_err++; $display("FAIL lat_out got v=%b d=%h want v=1 d=a5", bus.out_valid_o, bus.out_data_o); end
    n_cmp++; if (bus.address_released_onehot_o !== 8'h00) begin n_err++; $display("FAIL lat_pulse_len got %h want 00", bus.address_released_onehot_o); end
    adv();
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL lat_valid_fall got %b want 0", bus.out_valid_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 8'h00, 1'b1);
      n_cmp++; if (bus.alloc_onehot_o !== (8'h01 << i)) begin n_err++; $display("FAIL fill_alloc[%0d] got %h want %h", i, bus.alloc_onehot_o, 8'h01 << i); end
      adv();
    end
    drive(1'b0, 32'h0, 8'h08, 1'b1);
    n_cmp++; if (bus.in_ready_o !== 1'b0 || bus.alloc_onehot_o !== 8'h00) begin n_err++; $display("FAIL full got rdy=%b alloc=%h want 0/00", bus.in_ready_o, bus.alloc_onehot_o); end
    n_cmp++; if (bus.address_released_onehot_o !== 8'h08) begin n_err++; $display("FAIL fill_release got %h want 08", bus.address_released_onehot_o); end
    adv();
    drive(1'b1, 32'h13, 8'h00, 1'b1);
    n_cmp++; if (bus.in_ready_o !== 1'b1 || bus.alloc_onehot_o !== 8'h08) begin n_err++; $display("FAIL refree got rdy=%b alloc=%h want 1/08", bus.in_ready_o, bus.alloc_onehot_o); end
    n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h13) begin n_err++; $display("FAIL fill_out got v=%b d=%h want 1/13", bus.out_valid_o, bus.out_data_o); end
    adv();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 8'h0F & (8'hFF << k), 1'b1);
      n_cmp++; if (bus.address_released_onehot_o !== (8'h01 << k)) begin n_err++; $display("FAIL b2b_grant[%0d] got %h want %h", k, bus.address_released_onehot_o, 8'h01 << k); end
      if (k > 0) begin
        n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h10 + 32'(k - 1)) begin n_err++; $display("FAIL b2b_data[%0d] got v=%b d=%h want 1/%h", k, bus.out_valid_o, bus.out_data_o, 32'h10 + 32'(k - 1)); end
      end
      adv();
    end
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h13) begin n_err++; $display("FAIL b2b_last got v=%b d=%h want 1/13", bus.out_valid_o, bus.out_data_o); end
    adv();
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", bus.out_valid_o); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h20 + 32'(i), 8'h00, 1'b1);
      n_cmp++; if (bus.alloc_onehot_o !== (8'h01 << i)) begin n_err++; $display("FAIL bp_alloc[%0d] got %h want %h", i, bus.alloc_onehot_o, 8'h01 << i); end
      adv();
    end
    drive(1'b0, 32'h0, 8'h06, 1'b0);
    n_cmp++; if (bus.address_released_onehot_o !== 8'h02) begin n_err++; $display("FAIL bp_first got %h want 02", bus.address_released_onehot_o); end
    adv();
    for (int s = 0; s < 5; s++) begin
      drive(1'b0, 32'h0, 8'h04, 1'b0);
      n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h21 || bus.address_released_onehot_o !== 8'h00)
        begin n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%h rel=%h want 1/21/00", s, bus.out_valid_o, bus.out_data_o, bus.address_released_onehot_o); end
      adv();
    end
    drive(1'b0, 32'h0, 8'h04, 1'b1);
    n_cmp++; if (bus.address_released_onehot_o !== 8'h04) begin n_err++; $display("FAIL bp_resume got %h want 04", bus.address_released_onehot_o); end
    adv();
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h22) begin n_err++; $display("FAIL bp_second got v=%b d=%h want 1/22", bus.out_valid_o, bus.out_data_o); end
    adv();
  endtask

  task automatic test_round_robin();
    drive(1'b1, 32'h31, 8'h00, 1'b1);
    n_cmp++; if (bus.alloc_onehot_o !== 8'h02) begin n_err++; $display("FAIL rr_alloc got %h want 02", bus.alloc_onehot_o); end
    adv();
    drive(1'b0, 32'h0, 8'h02, 1'b1);
    adv();
    drive(1'b0, 32'h0, 8'h81, 1'b1);
    n_cmp++; if (bus.address_released_onehot_o !== 8'h80) begin n_err++; $display("FAIL rr_first got %h want 80", bus.address_released_onehot_o); end
    adv();
    drive(1'b0, 32'h0, 8'h01, 1'b1);
    n_cmp++; if (bus.address_released_onehot_o !== 8'h01 || bus.out_data_o !== 32'h17) begin n_err++; $display("FAIL rr_second got rel=%h d=%h want 01/17", bus.address_released_onehot_o, bus.out_data_o); end
    adv();
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h20) begin n_err++; $display("FAIL rr_data got v=%b d=%h want 1/20", bus.out_valid_o, bus.out_data_o); end
  endtask

  task automatic test_reset_mid();
    rst_i = 1'b1;
    adv();
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.alloc_onehot_o !== 8'h01 || bus.address_released_onehot_o !== 8'h00)
      begin n_err++; $display("FAIL midreset got v=%b rdy=%b alloc=%h rel=%h want 0/1/01/00", bus.out_valid_o, bus.in_ready_o, bus.alloc_onehot_o, bus.address_released_onehot_o); end
    adv();
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.address_released_onehot_o !== 8'h00) begin n_err++; $display("FAIL midreset_quiet got v=%b rel=%h want 0/00", bus.out_valid_o, bus.address_released_onehot_o); end
  endtask

  task automatic test_random();
    slot_onehot_t rel;
    int           a;
    int           g;
    logic         rdy;
    logic [7:0]   exp_alloc;
    logic [7:0]   exp_rel;
    for (int t = 0; t < 1500; t++) begin
      rel = '0;
      for (int k = 0; k < 8; k++) rel[k] = m_occ[k] && (cyc >= m_rt[k]);
      rdy = (t % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 2) != 0, $urandom, rel, rdy);
      a         = m_alloc();
      g         = m_grant(rel, rdy);
      exp_alloc = (a >= 0) ? (8'h01 << a) : 8'h00;
      exp_rel   = (g >= 0) ? (8'h01 << g) : 8'h00;
      n_cmp++; if (bus.alloc_onehot_o !== exp_alloc || bus.in_ready_o !== (a >= 0))
        begin n_err++; $display("FAIL rnd_alloc t=%0d got %h/%b want %h/%b", t, bus.alloc_onehot_o, bus.in_ready_o, exp_alloc, a >= 0); end
      n_cmp++; if (bus.address_released_onehot_o !== exp_rel)
        begin n_err++; $display("FAIL rnd_release t=%0d got %h want %h", t, bus.address_released_onehot_o, exp_rel); end
      n_cmp++; if (bus.out_valid_o !== m_ov || bus.out_data_o !== m_od)
        begin n_err++; $display("FAIL rnd_out t=%0d got %b/%h want %b/%h", t, bus.out_valid_o, bus.out_data_o, m_ov, m_od); end
      adv();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    test_reset();
    test_min_latency();
    test_fill();
    test_back_to_back();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
